// File: rtl/uc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, instruction decode constants, ULA operation and PC source codes.
package uc_pkg;

  typedef enum logic [4:0] {
    RST       = 5'd0,
    FETCH     = 5'd1,
    DECODE    = 5'd2,
    R_EXEC    = 5'd3,
    R_WB      = 5'd4,
    MEM_ADDR  = 5'd5,
    MEM_READ  = 5'd6,
    MEM_WB    = 5'd7,
    MEM_WRITE = 5'd8,
    BRANCH    = 5'd9,
    JUMP      = 5'd10,
    ADDI_EXEC = 5'd11,
    ADDI_WB   = 5'd12,
    EXC       = 5'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ULA_NOP = 3'd0;
  localparam logic [2:0] ULA_ADD = 3'd1;
  localparam logic [2:0] ULA_SUB = 3'd2;
  localparam logic [2:0] ULA_AND = 3'd3;

  localparam logic [1:0] PC_SRC_ULA    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_EXC    = 2'd3;

  localparam int WAIT_W = 4;

  // States that talk to memory and therefore stretch over MEM_LAT cycles.
  function automatic logic isMemState(state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/uc_wait_counter.sv
// Memory wait counter: counts cycles spent in a memory state and flags the
// last one so the FSM can leave after MEM_LAT cycles.
module uc_wait_counter
  import uc_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_LAT - 1);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == LAST);

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives PC, IR, memory, register-file and ULA controls from the state.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ULA_W   = 3,
  parameter int STATE_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               Load_PC,
  output logic               Load_PC_Cond,
  output logic               Empty_PC,
  output logic [1:0]         PC_Source,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ULASrcA,
  output logic [1:0]         ULASrcB,
  output logic [ULA_W-1:0]   Seletor_ULA,
  output logic               Exc,
  output logic [STATE_W-1:0] State
);

  state_t     state_q, state_d;
  logic       inMem, memDone, waitLoad, waitEn;
  logic [2:0] ulaSel;

  // Zero is applied by the datapath together with Load_PC_Cond, not here.
  logic unusedZero;
  assign unusedZero = Zero;

  assign inMem    = isMemState(state_q);
  assign waitLoad = !inMem || memDone;
  assign waitEn   = inMem && !memDone;

  uc_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .load_i (waitLoad),
    .en_i   (waitEn),
    .done_o (memDone)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:       state_d = FETCH;
      FETCH:     if (memDone) state_d = DECODE;
      DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = R_EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default:      state_d = EXC;
        endcase
      end
      R_EXEC: begin
        if (Funct == FN_ADD || Funct == FN_SUB || Funct == FN_AND) state_d = R_WB;
        else                                                       state_d = EXC;
      end
      MEM_ADDR: begin
        if (Opcode == OP_LW)      state_d = MEM_READ;
        else if (Opcode == OP_SW) state_d = MEM_WRITE;
        else                      state_d = EXC;
      end
      MEM_READ:  if (memDone) state_d = MEM_WB;
      MEM_WRITE: if (memDone) state_d = FETCH;
      ADDI_EXEC: state_d = ADDI_WB;
      R_WB, MEM_WB, ADDI_WB, BRANCH, JUMP, EXC: state_d = FETCH;
      default:   state_d = RST;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded straight from the state so an asynchronous reset
  // removes any write strobe within the same cycle.
  always_comb begin
    Load_PC      = 1'b0;
    Load_PC_Cond = 1'b0;
    Empty_PC     = 1'b0;
    PC_Source    = PC_SRC_ULA;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ULASrcA      = 1'b0;
    ULASrcB      = 2'd0;
    ulaSel       = ULA_NOP;
    Exc          = 1'b0;
    case (state_q)
      RST: Empty_PC = 1'b1;
      FETCH: begin
        MemRead = 1'b1;
        if (memDone) begin
          IRWrite   = 1'b1;
          Load_PC   = 1'b1;
          ULASrcB   = 2'd1;
          ulaSel    = ULA_ADD;
          PC_Source = PC_SRC_ULA;
        end
      end
      DECODE: begin
        ULASrcB = 2'd3;
        ulaSel  = ULA_ADD;
      end
      R_EXEC: begin
        ULASrcA = 1'b1;
        case (Funct)
          FN_ADD:  ulaSel = ULA_ADD;
          FN_SUB:  ulaSel = ULA_SUB;
          FN_AND:  ulaSel = ULA_AND;
          default: ulaSel = ULA_NOP;
        endcase
      end
      R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      MEM_ADDR, ADDI_EXEC: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'd2;
        ulaSel  = ULA_ADD;
      end
      MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      BRANCH: begin
        ULASrcA      = 1'b1;
        ulaSel       = ULA_SUB;
        Load_PC_Cond = 1'b1;
        PC_Source    = PC_SRC_ALUOUT;
      end
      JUMP: begin
        Load_PC   = 1'b1;
        PC_Source = PC_SRC_JUMP;
      end
      ADDI_WB: RegWrite = 1'b1;
      EXC: begin
        Exc       = 1'b1;
        Load_PC   = 1'b1;
        PC_Source = PC_SRC_EXC;
      end
      default: ;
    endcase
  end

  assign Seletor_ULA = ULA_W'(ulaSel);
  assign State       = STATE_W'(state_q);

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: three instances (MEM_LAT 1, 3, 4) share
// inputs and are checked against hand-computed per-cycle control values.
module tb_uc_multiciclo;

  localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_R_EXEC = 3, S_R_WB = 4;
  localparam int S_MEM_ADDR = 5, S_MEM_READ = 6, S_MEM_WB = 7, S_MEM_WRITE = 8;
  localparam int S_BRANCH = 9, S_JUMP = 10, S_EXC = 13;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode, Funct;
  logic       Zero;

  logic       loadPc[3], loadPcCond[3], emptyPc[3], iorD[3], memRead[3], memWrite[3];
  logic       irWrite[3], regDst[3], memtoReg[3], regWrite[3], ulaSrcA[3], exc[3];
  logic [1:0] pcSource[3], ulaSrcB[3];
  logic [2:0] sel[3];
  logic [4:0] state[3];

  int checkCount = 0;
  int passCount  = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    uc_multiciclo #(.MEM_LAT(LAT), .ULA_W(3), .STATE_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .Load_PC(loadPc[g]), .Load_PC_Cond(loadPcCond[g]), .Empty_PC(emptyPc[g]),
      .PC_Source(pcSource[g]), .IorD(iorD[g]), .MemRead(memRead[g]),
      .MemWrite(memWrite[g]), .IRWrite(irWrite[g]), .RegDst(regDst[g]),
      .MemtoReg(memtoReg[g]), .RegWrite(regWrite[g]), .ULASrcA(ulaSrcA[g]),
      .ULASrcB(ulaSrcB[g]), .Seletor_ULA(sel[g]), .Exc(exc[g]), .State(state[g])
    );
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
    Opcode = op;
    Funct  = fn;
    Zero   = z;
  endtask

  // Leaves every instance in RST with Reset released, just after a clock edge.
  task automatic doReset();
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
  endtask

  // Starting on the first FETCH cycle, counts cycles until the next FETCH entry.
  task automatic runInstr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                          input int expected, input string tag);
    int  cycles = 1;
    bit  left = 0;
    bit  done = 0;
    applyStimulus(op, fn, 1'b0);
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (int'(state[idx]) != S_FETCH) left = 1;
      else if (left) done = 1;
      if (!done) cycles++;
    end
    checkOutput(tag, cycles, expected);
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(6'h00, 6'h20, 1'b0);

    // Reset behaviour and first fetch
    repeat (3) step();
    checkOutput("rst_state_held", state[0], S_RST);
    checkOutput("rst_empty_held", emptyPc[0], 1);
    Reset = 1'b0;
    checkOutput("rst_state", state[0], S_RST);
    checkOutput("rst_empty_pc", emptyPc[0], 1);
    checkOutput("rst_writes", {loadPc[0], irWrite[0], regWrite[0], memWrite[0], memRead[0]}, 0);
    step();
    checkOutput("fetch_state", state[0], S_FETCH);
    checkOutput("fetch_memread", memRead[0], 1);
    checkOutput("fetch_irwrite", irWrite[0], 1);
    checkOutput("fetch_loadpc", loadPc[0], 1);
    checkOutput("fetch_ula", sel[0], 1);
    checkOutput("fetch_srcb", ulaSrcB[0], 1);
    checkOutput("fetch_empty", emptyPc[0], 0);
    checkOutput("fetch3_first_irwrite", irWrite[1], 0);
    checkOutput("fetch3_first_memread", memRead[1], 1);

    // R-type SUB at MEM_LAT=1
    applyStimulus(6'h00, 6'h22, 1'b0);
    doReset();
    step();
    step();
    checkOutput("sub_decode", state[0], S_DECODE);
    checkOutput("sub_decode_srcb", ulaSrcB[0], 3);
    checkOutput("sub_decode_ula", sel[0], 1);
    step();
    checkOutput("sub_exec", state[0], S_R_EXEC);
    checkOutput("sub_exec_ula", sel[0], 2);
    checkOutput("sub_exec_src", {ulaSrcA[0], ulaSrcB[0]}, 3'b100);
    step();
    checkOutput("sub_wb", state[0], S_R_WB);
    checkOutput("sub_wb_ctl", {regWrite[0], regDst[0], memtoReg[0]}, 3'b110);
    step();
    checkOutput("sub_back_fetch", state[0], S_FETCH);

    // Cycle counts at MEM_LAT=1, back to back from FETCH
    runInstr(0, 6'h00, 6'h20, 4, "cyc_add");
    runInstr(0, 6'h00, 6'h24, 4, "cyc_and");
    runInstr(0, 6'h23, 6'h00, 5, "cyc_lw");
    runInstr(0, 6'h2B, 6'h00, 4, "cyc_sw");
    runInstr(0, 6'h04, 6'h00, 3, "cyc_beq");
    runInstr(0, 6'h02, 6'h00, 3, "cyc_j");
    runInstr(0, 6'h08, 6'h00, 4, "cyc_addi");
    runInstr(0, 6'h3F, 6'h00, 3, "cyc_illegal");

    // lw at MEM_LAT=3
    applyStimulus(6'h23, 6'h00, 1'b0);
    doReset();
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput($sformatf("lw3_fetch%0d", c), {state[1], memRead[1], iorD[1], irWrite[1]},
                  {5'(S_FETCH), 1'b1, 1'b0, (c == 2) ? 1'b1 : 1'b0});
    end
    step();
    checkOutput("lw3_decode", state[1], S_DECODE);
    step();
    checkOutput("lw3_addr", {state[1], ulaSrcA[1], ulaSrcB[1], sel[1]}, {5'(S_MEM_ADDR), 1'b1, 2'd2, 3'd1});
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput($sformatf("lw3_read%0d", c), {state[1], memRead[1], iorD[1]}, {5'(S_MEM_READ), 1'b1, 1'b1});
    end
    step();
    checkOutput("lw3_wb", {state[1], memtoReg[1], regWrite[1], regDst[1]}, {5'(S_MEM_WB), 1'b1, 1'b1, 1'b0});
    step();
    checkOutput("lw3_back_fetch", state[1], S_FETCH);
    runInstr(1, 6'h23, 6'h00, 9, "cyc3_lw");
    runInstr(1, 6'h2B, 6'h00, 8, "cyc3_sw");

    // beq with Zero=1 and Zero=0 gives identical control outputs
    for (int z = 1; z >= 0; z--) begin
      applyStimulus(6'h04, 6'h00, z[0]);
      doReset();
      repeat (3) step();
      checkOutput($sformatf("beq_z%0d", z),
                  {state[0], loadPcCond[0], pcSource[0], sel[0], loadPc[0], ulaSrcA[0]},
                  {5'(S_BRANCH), 1'b1, 2'd1, 3'd2, 1'b0, 1'b1});
    end

    // jump
    applyStimulus(6'h02, 6'h00, 1'b0);
    doReset();
    repeat (3) step();
    checkOutput("jump_ctl", {state[0], loadPc[0], pcSource[0]}, {5'(S_JUMP), 1'b1, 2'd2});

    // illegal opcode
    applyStimulus(6'h3F, 6'h00, 1'b0);
    doReset();
    repeat (2) step();
    checkOutput("illop_decode_exc", exc[0], 0);
    step();
    checkOutput("illop_exc", {state[0], exc[0], pcSource[0], loadPc[0], regWrite[0]},
                {5'(S_EXC), 1'b1, 2'd3, 1'b1, 1'b0});
    step();
    checkOutput("illop_pulse_end", {state[0], exc[0]}, {5'(S_FETCH), 1'b0});

    // illegal funct
    applyStimulus(6'h00, 6'h27, 1'b0);
    doReset();
    repeat (3) step();
    checkOutput("illfn_rexec", {state[0], regWrite[0], exc[0]}, {5'(S_R_EXEC), 1'b0, 1'b0});
    step();
    checkOutput("illfn_exc", {state[0], exc[0], pcSource[0], loadPc[0], regWrite[0]},
                {5'(S_EXC), 1'b1, 2'd3, 1'b1, 1'b0});
    step();
    checkOutput("illfn_pulse_end", {state[0], exc[0], regWrite[0]}, {5'(S_FETCH), 1'b0, 1'b0});

    // Reset during the 2nd MEM_WRITE cycle at MEM_LAT=4
    applyStimulus(6'h2B, 6'h00, 1'b0);
    doReset();
    repeat (7) step();
    checkOutput("sw4_write1", {state[2], memWrite[2], iorD[2]}, {5'(S_MEM_WRITE), 1'b1, 1'b1});
    step();
    checkOutput("sw4_write2", {state[2], memWrite[2], memRead[2]}, {5'(S_MEM_WRITE), 1'b1, 1'b0});
    Reset = 1'b1;
    #1;
    checkOutput("sw4_async_rst", {state[2], memWrite[2], emptyPc[2]}, {5'(S_RST), 1'b0, 1'b1});
    step();
    Reset = 1'b0;
    step();
    checkOutput("sw4_resume", {state[2], memRead[2], memWrite[2]}, {5'(S_FETCH), 1'b1, 1'b0});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multicycle MIPS control unit. Sequences fetch, decode, execute, memory and writeback for R-type (add/sub/and), lw, sw, beq, j and addi.
- Drives PC, instruction register (IR), memory, register-file and ALU (ULA) control.
- Supports a parametrised memory latency and traps illegal instructions to a fixed exception vector.
- Sits between the IR decode fields and the datapath muxes/enables.

Parameters:
- MEM_LAT, 1, memory read/write latency in cycles (1..15); memory states hold for this many cycles.
- ULA_W, 3, width of the Seletor_ULA code.
- STATE_W, 5, width of the debug state output.

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Opcode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ULA zero flag
- Load_PC  out  1  unconditional PC write
- Load_PC_Cond  out  1  PC write qualified by Zero (beq)
- Empty_PC  out  1  clear PC to 0
- PC_Source  out  2  0=ULA result, 1=ALUOut, 2=jump target, 3=exception vector
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- RegDst  out  1  write register: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write
- ULASrcA  out  1  ULA A input: 0=PC, 1=regA
- ULASrcB  out  2  ULA B input: 0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- Seletor_ULA  out  ULA_W  ULA operation code
- Exc  out  1  illegal-instruction pulse
- State  out  STATE_W  current state encoding, for debug

Behaviour:
- All outputs are combinational from the state and, in DECODE/R_EXEC, from Opcode/Funct. Unlisted outputs are 0 in every state; Seletor_ULA defaults to ULA_NOP.
- Reset=1 forces state RST asynchronously; while in RST only Empty_PC=1.
- States and transitions:
  - RST: Empty_PC=1 -> FETCH.
  - FETCH: MemRead=1, IorD=0; held for MEM_LAT cycles via wait counter.
    - Final cycle also: IRWrite=1, Load_PC=1, ULASrcA=0, ULASrcB=1, ULA_ADD, PC_Source=0.
    - -> DECODE.
  - DECODE: ULASrcA=0, ULASrcB=3, ULA_ADD (branch target into ALUOut). Dispatch on Opcode:
    - 0x00 -> R_EXEC
    - 0x23, 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDI_EXEC
    - anything else -> EXC.
  - R_EXEC: ULASrcA=1, ULASrcB=0. Funct 0x20=ADD, 0x22=SUB, 0x24=AND -> R_WB. Any other Funct -> EXC; no register write occurs.
  - R_WB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - MEM_ADDR: ULASrcA=1, ULASrcB=2, ULA_ADD. Opcode 0x23 -> MEM_READ; 0x2B -> MEM_WRITE.
  - MEM_READ: IorD=1, MemRead=1 for MEM_LAT cycles -> MEM_WB.
  - MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEM_WRITE: IorD=1, MemWrite=1 for MEM_LAT cycles -> FETCH.
  - BRANCH: ULASrcA=1, ULASrcB=0, ULA_SUB, Load_PC_Cond=1, PC_Source=1 -> FETCH.
  - JUMP: Load_PC=1, PC_Source=2 -> FETCH.
  - ADDI_EXEC: ULASrcA=1, ULASrcB=2, ULA_ADD -> ADDI_WB.
  - ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - EXC: Exc=1, Load_PC=1, PC_Source=3 -> FETCH. Exc is a one-cycle pulse.
- Wait counter:
  - 4 bits; loads 0 on entry to any memory state and increments each cycle in that state.
  - The state exits when counter == MEM_LAT-1.
  - MEM_LAT=1 gives single-cycle memory states.
  - Counter resets to 0 on Reset.
- Cycle counts at MEM_LAT=1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 3. Each memory state adds MEM_LAT-1 cycles.
- Reset mid-instruction: abandon immediately; no write strobe may be asserted on the cycle Reset is high.
- MemRead and MemWrite are never both 1. RegWrite and Load_PC are never both 1 except in FETCH and EXC, where RegWrite is 0.

Decomposition:
- Package uc_pkg holds:
  - state_t enum (RST, FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, EXC);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - funct constants FN_ADD, FN_SUB, FN_AND;
  - ULA codes ULA_NOP=0, ULA_ADD=1, ULA_SUB=2, ULA_AND=3;
  - PC_Source codes.
- Sub-module uc_wait_counter (load, enable, terminal-count compare against MEM_LAT) is the one natural split. The FSM stays in one module.

Test Plan:
- Reset=1 for 3 cycles, then release -> one RST cycle with Empty_PC=1 and all writes 0; next cycle FETCH with MemRead=1, IRWrite=1, Load_PC=1, Seletor_ULA=1.
- Opcode=0x00, Funct=0x22, MEM_LAT=1 -> FETCH, DECODE, R_EXEC (Seletor_ULA=2), R_WB (RegWrite=1, RegDst=1), then FETCH; 4 cycles total.
- Opcode=0x23, MEM_LAT=3 -> MemRead high 3 cycles in FETCH and 3 in MEM_READ, then MEM_WB with MemtoReg=1; 9 cycles total.
- Opcode=0x04, Zero=1 -> BRANCH cycle with Load_PC_Cond=1, PC_Source=1, Seletor_ULA=2; with Zero=0 the same outputs appear and the datapath must not update PC.
- Opcode=0x3F, or Opcode=0 with Funct=0x27 -> Exc=1 for exactly one cycle with PC_Source=3 and Load_PC=1; RegWrite never asserted.
- Reset asserted during MEM_WRITE (MEM_LAT=4, 2nd cycle) -> MemWrite drops in that same cycle and state goes to RST; after release the unit resumes at FETCH.
